adc_spi_master: RTL

ADC_SPI_MASTER -- requirements
Module: adc_spi_master

---
 rtl/adc_spi_pkg.sv | 22 ++
 rtl/spi_clk_gen.sv | 30 +++
 rtl/adc_spi_master.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/adc_spi_pkg.sv
// rtl/adc_spi_pkg.sv - frame constants, state encoding and frame builder for the ADC SPI master
package adc_spi_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int ADDR_W       = 3;
    localparam int ADDR_MSB_POS = 13;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_QUIET = 3'd4;

    // Command word sent to the ADC: channel address in bits 13..11, all else zero.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [ADDR_W-1:0] addr);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[ADDR_MSB_POS -: ADDR_W] = addr;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period counter; o_tick marks the last cycle of each half-period
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [7:0] o_cnt,
    output logic       o_tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    assign o_tick = i_en && !i_clr && (r_cnt == LAST);
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/adc_spi_master.sv
// rtl/adc_spi_master.sv - SPI master for a 16-bit-frame multiplexed ADC; reports the previous frame's channel
module adc_spi_master
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [2:0]        channel_addr,
    input  logic              start,
    input  logic              miso,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    output logic              busy,
    output logic [DATA_W-1:0] sample_data,
    output logic [2:0]        sample_channel,
    output logic              sample_valid
);

    localparam logic [7:0] QUIET_LAST = 8'(CLK_DIV - 2);
    localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);

    logic [2:0]            r_state;
    logic                  r_sclk;
    logic                  r_cs_n;
    logic                  r_mosi;
    logic                  r_busy;
    logic                  r_sample_valid;
    logic [DATA_W-1:0]     r_sample_data;
    logic [2:0]            r_sample_channel;
    logic [ADDR_W-1:0]     r_addr_lat;
    logic [ADDR_W-1:0]     r_prev_addr;
    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_bit_cnt;

    logic [7:0]            w_cnt;
    logic                  w_tick;
    logic                  w_quiet_done;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk    (clk),
        .resetn (resetn),
        .i_en   (r_state != ST_IDLE),
        .i_clr  (r_state == ST_IDLE),
        .o_cnt  (w_cnt),
        .o_tick (w_tick)
    );

    // The IDLE cycle that follows QUIET completes the CLK_DIV-cycle deselect gap.
    assign w_quiet_done = (w_cnt == QUIET_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= ST_IDLE;
            r_sclk           <= 1'b1;
            r_cs_n           <= 1'b1;
            r_mosi           <= 1'b0;
            r_busy           <= 1'b0;
            r_sample_valid   <= 1'b0;
            r_sample_data    <= '0;
            r_sample_channel <= '0;
            r_addr_lat       <= '0;
            r_prev_addr      <= '0;
            r_tx             <= '0;
            r_shift          <= '0;
            r_bit_cnt        <= '0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_SETUP;
                        r_busy     <= 1'b1;
                        r_cs_n     <= 1'b0;
                        r_addr_lat <= channel_addr;
                        r_tx       <= build_frame(channel_addr);
                        r_bit_cnt  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                        r_sclk  <= 1'b0;
                        r_mosi  <= r_tx[FRAME_BITS-1];
                        r_tx    <= r_tx << 1;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (!r_sclk) begin
                            r_sclk  <= 1'b1;
                            r_shift <= (r_shift << 1) | {{(FRAME_BITS-1){1'b0}}, miso};
                        end else if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_sclk    <= 1'b0;
                            r_mosi    <= r_tx[FRAME_BITS-1];
                            r_tx      <= r_tx << 1;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_state          <= ST_QUIET;
                        r_cs_n           <= 1'b1;
                        r_mosi           <= 1'b0;
                        r_sample_valid   <= 1'b1;
                        r_sample_data    <= r_shift[DATA_W-1:0];
                        r_sample_channel <= r_prev_addr;
                        r_prev_addr      <= r_addr_lat;
                    end
                end
                ST_QUIET: begin
                    if (w_quiet_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b1;
                end
            endcase
        end
    end

    assign sclk           = r_sclk;
    assign cs_n           = r_cs_n;
    assign mosi           = r_mosi;
    assign busy           = r_busy;
    assign sample_data    = r_sample_data;
    assign sample_channel = r_sample_channel;
    assign sample_valid   = r_sample_valid;

endmodule
